// File: rtl/bnn_neuron_seq_pkg.sv
// Shared definitions for the binarized-neuron sequencer: state encoding,
// ALU op codes and the default accumulator width.
package bnn_neuron_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic OP_ADD1 = 1'b0;
    localparam logic OP_SUB1 = 1'b1;

    localparam int DEFAULT_ACC_WIDTH = 12;

endpackage

// File: rtl/bnn_neuron_seq_alu.sv
// Plus/minus-one ALU: adds +1 (OP_ADD1) or -1 (OP_SUB1) to alu_in_b when
// alu_in_a_lsb is set, otherwise passes alu_in_b through. Wraps; no saturation.
module bnn_neuron_seq_alu
    import bnn_neuron_seq_pkg::*;
#(
    parameter int ALU_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic                 alu_in_a_lsb,
    input  logic                 alu_op,
    input  logic [ALU_WIDTH-1:0] alu_in_b,
    output logic [ALU_WIDTH-1:0] alu_out
);

    logic signed [ALU_WIDTH-1:0] step;
    logic signed [ALU_WIDTH-1:0] sum;

    // Step is 0, +1, or all-ones (-1) depending on enable and op.
    assign step    = {{(ALU_WIDTH-1){alu_in_a_lsb & (alu_op == OP_SUB1)}}, alu_in_a_lsb};
    assign sum     = $signed(alu_in_b) + step;
    assign alu_out = sum;

endmodule

// File: rtl/bnn_neuron_seq.sv
// Bit-serial binarized neuron: bias-loaded saturating +/-1 accumulator over
// N_INPUTS (x_bit, w_bit) beats, then presents sign bit and sum until accepted.
module bnn_neuron_seq
    import bnn_neuron_seq_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int N_INPUTS  = 784,
    parameter int CNT_WIDTH = $clog2(N_INPUTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 x_bit,
    input  logic                 w_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 busy
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]        CNT_LAST = CNT_WIDTH'(N_INPUTS - 1);

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]        alu_out;
    logic                        beat;
    logic                        op;
    logic                        sat_hold;

    assign beat = in_valid & (state_q == ST_ACCUM);
    assign op   = x_bit ^ w_bit;

    bnn_neuron_seq_alu #(
        .ALU_WIDTH (ACC_WIDTH)
    ) u_alu (
        .alu_in_a_lsb (beat),
        .alu_op       (op),
        .alu_in_b     (acc_q),
        .alu_out      (alu_out)
    );

    // At either rail the step toward overflow is dropped instead of wrapping.
    assign sat_hold = ((op == OP_ADD1) && (acc_q == ACC_MAX)) ||
                      ((op == OP_SUB1) && (acc_q == ACC_MIN));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    if (!sat_hold) begin
                        acc_d = alu_out;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from state and the registered accumulator only.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_bit   = (state_q == ST_DONE) & ~acc_q[ACC_WIDTH-1];
    assign out_sum   = (state_q == ST_DONE) ? acc_q : '0;

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Randomized self-checking bench for bnn_neuron_seq: three instances
// (N=4/12-bit, N=4/4-bit, default N=784/12-bit) against a saturating-sum model.
module tb_bnn_neuron_seq;

    logic        clk;
    logic        rst;
    logic        start_v;
    logic [11:0] bias;
    logic        in_valid;
    logic        x_bit;
    logic        w_bit;
    logic        out_ready;

    logic        start_a, start_b, start_c;
    logic        ready_a, ready_b, ready_c;
    logic        valid_a, valid_b, valid_c;
    logic        bit_a, bit_b, bit_c;
    logic        busy_a, busy_b, busy_c;
    logic [11:0] sum_a;
    logic [3:0]  sum_b;
    logic [11:0] sum_c;

    int sel;
    int obs_ready, obs_valid, obs_bit, obs_busy, obs_sum;
    int n_cmp, n_bad;

    bit xs [784];
    bit ws [784];

    assign start_a = start_v && (sel == 0);
    assign start_b = start_v && (sel == 1);
    assign start_c = start_v && (sel == 2);

    bnn_neuron_seq #(.ACC_WIDTH(12), .N_INPUTS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .bias(bias),
        .in_valid(in_valid), .in_ready(ready_a), .x_bit(x_bit), .w_bit(w_bit),
        .out_valid(valid_a), .out_ready(out_ready), .out_bit(bit_a),
        .out_sum(sum_a), .busy(busy_a)
    );

    bnn_neuron_seq #(.ACC_WIDTH(4), .N_INPUTS(4)) u_sat (
        .clk(clk), .rst(rst), .start(start_b), .bias(bias[3:0]),
        .in_valid(in_valid), .in_ready(ready_b), .x_bit(x_bit), .w_bit(w_bit),
        .out_valid(valid_b), .out_ready(out_ready), .out_bit(bit_b),
        .out_sum(sum_b), .busy(busy_b)
    );

    bnn_neuron_seq u_big (
        .clk(clk), .rst(rst), .start(start_c), .bias(bias),
        .in_valid(in_valid), .in_ready(ready_c), .x_bit(x_bit), .w_bit(w_bit),
        .out_valid(valid_c), .out_ready(out_ready), .out_bit(bit_c),
        .out_sum(sum_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_ready = 0;
        obs_valid = 0;
        obs_bit   = 0;
        obs_busy  = 0;
        obs_sum   = 0;
        case (sel)
            0: begin
                obs_ready = int'(ready_a); obs_valid = int'(valid_a);
                obs_bit = int'(bit_a); obs_busy = int'(busy_a);
                obs_sum = int'($signed(sum_a));
            end
            1: begin
                obs_ready = int'(ready_b); obs_valid = int'(valid_b);
                obs_bit = int'(bit_b); obs_busy = int'(busy_b);
                obs_sum = int'($signed(sum_b));
            end
            default: begin
                obs_ready = int'(ready_c); obs_valid = int'(valid_c);
                obs_bit = int'(bit_c); obs_busy = int'(busy_c);
                obs_sum = int'($signed(sum_c));
            end
        endcase
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 4 : 12;
    endfunction

    // Reference: start at bias, +1 per matching pair, -1 per mismatch, clamp at the rails.
    function automatic int ref_sum(input int w, input int b, input int n);
        int lo, hi, acc;
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        acc = b;
        for (int i = 0; i < n; i++) begin
            if (xs[i] == ws[i]) acc = (acc < hi) ? acc + 1 : acc;
            else                acc = (acc > lo) ? acc - 1 : acc;
        end
        return acc;
    endfunction

    task automatic set_pairs(input int n, input int mode);
        // mode 0: all matched, 1: all mismatched, 2: random
        for (int i = 0; i < n; i++) begin
            xs[i] = bit'($urandom_range(1));
            case (mode)
                0:       ws[i] = xs[i];
                1:       ws[i] = ~xs[i];
                default: ws[i] = bit'($urandom_range(1));
            endcase
        end
    endtask

    task automatic run_eval(input int s, input int b, input int n, input int exp_sum,
                            input int bub, input int stall, input bit noise);
        int idx, edges, nbub, guard, w;
        bit took;
        sel      = s;
        bias     = 12'(b);
        in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        start_v  = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        edges   = 1;
        chk_eq("accum_ready", obs_ready, 1);
        chk_eq("accum_busy", obs_busy, 1);
        chk_eq("accum_valid", obs_valid, 0);
        idx = 0; nbub = 0; guard = 0;
        while (idx < n && guard < 4 * n + 50) begin
            in_valid = ($urandom_range(99) >= bub);
            x_bit    = xs[idx];
            w_bit    = ws[idx];
            start_v  = noise && ($urandom_range(3) == 0);
            if (!in_valid) nbub++;
            took = in_valid && (obs_ready == 1);
            @(posedge clk); #1;
            edges++; guard++;
            if (took) idx++;
        end
        in_valid = 1'b0;
        start_v  = 1'b0;
        if (idx < n) chk_eq("beat_timeout", idx, n);
        w = 0;
        while (obs_valid != 1 && w < 10) begin
            @(posedge clk); #1;
            edges++; w++;
        end
        chk_eq("out_valid", obs_valid, 1);
        chk_eq("latency", edges, n + nbub + 1);
        out_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
            start_v  = noise ? 1'($urandom_range(1)) : 1'b0;
            in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
            @(posedge clk); #1;
            chk_eq("stall_valid", obs_valid, 1);
            chk_eq("stall_sum", obs_sum, exp_sum);
            chk_eq("stall_bit", obs_bit, int'(exp_sum >= 0));
        end
        start_v = 1'b0;
        chk_eq("done_sum", obs_sum, exp_sum);
        chk_eq("done_bit", obs_bit, int'(exp_sum >= 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk_eq("idle_valid", obs_valid, 0);
        chk_eq("idle_busy", obs_busy, 0);
        chk_eq("idle_sum", obs_sum, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_ready"}, obs_ready, 0);
        chk_eq({tag, "_valid"}, obs_valid, 0);
        chk_eq({tag, "_bit"}, obs_bit, 0);
        chk_eq({tag, "_sum"}, obs_sum, 0);
        chk_eq({tag, "_busy"}, obs_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, lo, hi, s;
        n_cmp = 0; n_bad = 0;
        sel = 0; start_v = 1'b0; bias = '0; in_valid = 1'b0;
        x_bit = 1'b0; w_bit = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            chk_zero("reset");
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed 4-input cases on the 12-bit instance.
        xs[0] = 1; ws[0] = 1; xs[1] = 0; ws[1] = 0;
        xs[2] = 1; ws[2] = 0; xs[3] = 1; ws[3] = 1;
        run_eval(0, 0, 4, 2, 0, 0, 1'b0);
        run_eval(0, 0, 4, 2, 30, 10, 1'b1);
        set_pairs(4, 1);
        run_eval(0, 1, 4, -3, 0, 2, 1'b0);
        set_pairs(4, 0);
        run_eval(0, -4, 4, 0, 0, 2, 1'b0);

        // Saturation on the 4-bit instance.
        set_pairs(4, 0);
        run_eval(1, 6, 4, 7, 0, 1, 1'b0);
        set_pairs(4, 1);
        run_eval(1, -7, 4, -8, 0, 1, 1'b0);

        // Randomized runs, with biases near the rails every few trials.
        for (int t = 0; t < 24; t++) begin
            s  = t % 2;
            lo = -(1 << (width_of(s) - 1));
            hi = (1 << (width_of(s) - 1)) - 1;
            case (t % 4)
                0:       b = hi - int'($urandom_range(1));
                1:       b = lo + int'($urandom_range(1));
                default: b = lo + int'($urandom_range(hi - lo));
            endcase
            set_pairs(4, 2);
            run_eval(s, b, 4, ref_sum(width_of(s), b, 4), 30, int'($urandom_range(10)), 1'b1);
        end

        // Reset in the middle of an evaluation.
        sel = 0; bias = '0; start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0; in_valid = 1'b1; x_bit = 1'b1; w_bit = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        #1 rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk_eq("post_rst_valid", obs_valid, 0);
        chk_eq("post_rst_busy", obs_busy, 0);
        set_pairs(4, 0);
        run_eval(0, 0, 4, 4, 0, 0, 1'b0);

        // Default-size instance.
        set_pairs(784, 0);
        run_eval(2, 0, 784, 784, 0, 1, 1'b0);
        set_pairs(784, 2);
        b = -100 + int'($urandom_range(200));
        run_eval(2, b, 784, ref_sum(12, b, 784), 20, 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bnn_neuron_seq.md
# bnn_neuron_seq

Bit-serial binarized-neuron sequencer that drives the 12-bit ±1 ALU datapath. It loads a signed bias, then accepts one (input bit, weight bit) pair per handshake and adds +1 or −1 to a saturating accumulator. After exactly N_INPUTS pairs it presents the sign-activated output bit and the raw sum to the next layer. It sits between the layer's input/weight streamers and the activation buffer, one instance per neuron lane.

## Interface
- ACC_WIDTH, 12, accumulator and bias width in bits (signed).
- N_INPUTS, 784, pairs per neuron evaluation; must be ≥1 and < 2^(ACC_WIDTH−1).
- CNT_WIDTH, $clog2(N_INPUTS+1), beat counter width (derived).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- bias  in  ACC_WIDTH  signed initial accumulator value, captured with start.
- in_valid  in  1  x_bit/w_bit valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- x_bit  in  1  binarized activation (1 = +1, 0 = −1).
- w_bit  in  1  binarized weight, same encoding.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_bit  out  1  activation: 1 when sum ≥ 0, else 0.
- out_sum  out  ACC_WIDTH  signed final sum.
- busy  out  1  high in ACCUM or DONE.

## Operation
- States: IDLE → ACCUM → DONE → IDLE.
- IDLE: in_ready=0, out_valid=0. start=1 → acc ← bias, cnt ← 0, go to ACCUM.
- ACCUM: in_ready=1. On beat (in_valid & in_ready): op = x_bit ^ w_bit; op=0 (match) → acc+1, op=1 (mismatch) → acc−1; cnt+1. The beat with cnt==N_INPUTS−1 moves to DONE.
- Saturation: +1 at acc = 2^(ACC_WIDTH−1)−1 holds; −1 at acc = −2^(ACC_WIDTH−1) holds. No wrap.
- DONE: out_valid=1, out_sum=acc, out_bit=~acc[MSB]. Outputs stay stable until out_valid & out_ready, then return to IDLE in the following cycle.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored and no state changes.
- The start and out_ready handshake do not overlap; a new start is accepted only once the block is back in IDLE. Back-to-back evaluation therefore costs one IDLE cycle.

## Timing
- Reset (async assert; deassertion synchronized by the system): state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_bit=0, out_sum=0, busy=0.
- rst mid-evaluation aborts it immediately. The partial sum is discarded and no out_valid pulse is produced.
- start at edge t puts the block in ACCUM at t+1, so in_ready=1 from cycle t+1.
- Each beat updates acc at the same edge. Bubbles (in_valid=0) hold acc and cnt.
- When the last beat is taken at edge t, out_valid=1 in cycle t+1. Minimum evaluation latency is N_INPUTS+1 cycles from start to out_valid.
- All outputs are registered or decoded directly from the state. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Shared package: state encoding (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), op constants OP_ADD1=1'b0 and OP_SUB1=1'b1, and the default ACC_WIDTH.
- One sub-module: the existing ±1 ALU, instantiated with alu_in_a_lsb = beat, alu_op = x_bit ^ w_bit, alu_in_b = acc, alu_width = ACC_WIDTH. The sequencer applies saturation by selecting acc instead of alu_out at the limits.

## Test plan
- N_INPUTS=4, bias=0, pairs (1,1),(0,0),(1,0),(1,1) with no bubbles → out_valid 5 cycles after start, out_sum=2, out_bit=1.
- N_INPUTS=4, bias=1, all pairs mismatched → out_sum=−3, out_bit=0. Then bias=−4 with all pairs matched → out_sum=0, out_bit=1 (boundary: zero maps to 1).
- Saturation, ACC_WIDTH=4: bias=6 and 4 matched pairs → out_sum=7. bias=−7 and 4 mismatched pairs → out_sum=−8.
- Random in_valid bubbles and out_ready held low for 10 cycles → same sum as the no-bubble run; out_sum and out_bit stable while stalled; start pulses during ACCUM/DONE ignored.
- rst asserted after 2 of 4 beats → all outputs 0 on the same cycle. A fresh start with bias=0 and 4 matched pairs then gives out_sum=4.
- Default N_INPUTS=784, bias=0, all matched pairs → out_sum=784, out_bit=1, latency 785 cycles.
